// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath/memory.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              m_i_if_req;
    logic [AWIDTH-1:0] m_i_if_addr;
    logic              m_o_if_ack;
    logic [DWIDTH-1:0] m_o_if_rdata;
    logic              m_o_if_stall;
    logic              m_i_ds_req;
    logic              m_i_ds_we;
    logic [AWIDTH-1:0] m_i_ds_addr;
    logic [DWIDTH-1:0] m_i_ds_wdata;
    logic              m_o_ds_ack;
    logic [DWIDTH-1:0] m_o_ds_rdata;
    logic              m_o_mem_en;
    logic              m_o_mem_we;
    logic [AWIDTH-1:0] m_o_mem_addr;
    logic [DWIDTH-1:0] m_o_mem_wdata;
    logic [DWIDTH-1:0] m_i_mem_rdata;
    logic              m_o_busy;

    modport slave (
        input  m_i_if_req, m_i_if_addr, m_i_ds_req, m_i_ds_we, m_i_ds_addr,
               m_i_ds_wdata, m_i_mem_rdata,
        output m_o_if_ack, m_o_if_rdata, m_o_if_stall, m_o_ds_ack, m_o_ds_rdata,
               m_o_mem_en, m_o_mem_we, m_o_mem_addr, m_o_mem_wdata, m_o_busy
    );

    modport master (
        output m_i_if_req, m_i_if_addr, m_i_ds_req, m_i_ds_we, m_i_ds_addr,
               m_i_ds_wdata, m_i_mem_rdata,
        input  m_o_if_ack, m_o_if_rdata, m_o_if_stall, m_o_ds_ack, m_o_ds_rdata,
               m_o_mem_en, m_o_mem_we, m_o_mem_addr, m_o_mem_wdata, m_o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// data has priority, fetch is forced after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                m_clk,
    input  logic                m_rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_r, state_s;
    owner_t            owner_r, owner_s;
    logic [3:0]        lat_cnt_r, lat_cnt_s;
    logic [3:0]        starve_cnt_r, starve_cnt_s;
    logic              if_ack_r, if_ack_s;
    logic              ds_ack_r, ds_ack_s;
    logic [DWIDTH-1:0] if_rdata_r, if_rdata_s;
    logic [DWIDTH-1:0] ds_rdata_r, ds_rdata_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_we_r, mem_we_s;
    logic [AWIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [DWIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic              grant_data_s;

    // Next-state, arbitration and next-value logic for every register.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        lat_cnt_s    = lat_cnt_r;
        starve_cnt_s = starve_cnt_r;
        if_ack_s     = 1'b0;
        ds_ack_s     = 1'b0;
        if_rdata_s   = if_rdata_r;
        ds_rdata_s   = ds_rdata_r;
        mem_en_s     = 1'b0;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        grant_data_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.m_i_if_req || bus.m_i_ds_req) begin
                    // Command registers are loaded here so mem_en is a clean flop output in ISSUE.
                    grant_data_s = bus.m_i_ds_req &&
                                   !(bus.m_i_if_req && (starve_cnt_r == STARVE_MAX));
                    mem_en_s     = 1'b1;
                    state_s      = ST_ISSUE;
                    if (grant_data_s) begin
                        owner_s     = OWN_DATA;
                        mem_we_s    = bus.m_i_ds_we;
                        mem_addr_s  = bus.m_i_ds_addr;
                        mem_wdata_s = bus.m_i_ds_wdata;
                        if (bus.m_i_if_req && (starve_cnt_r != STARVE_MAX)) begin
                            starve_cnt_s = starve_cnt_r + 4'd1;
                        end else begin
                            starve_cnt_s = starve_cnt_r;
                        end
                    end else begin
                        owner_s      = OWN_FETCH;
                        mem_we_s     = 1'b0;
                        mem_addr_s   = bus.m_i_if_addr;
                        mem_wdata_s  = {DWIDTH{1'b0}};
                        starve_cnt_s = 4'd0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                lat_cnt_s = LAT_LOAD;
                state_s   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_r != 4'd0) begin
                    lat_cnt_s = lat_cnt_r - 4'd1;
                end else begin
                    state_s = ST_RESP;
                    if (!mem_we_r && (owner_r == OWN_DATA)) begin
                        ds_rdata_s = bus.m_i_mem_rdata;
                    end else if (!mem_we_r) begin
                        if_rdata_s = bus.m_i_mem_rdata;
                    end else begin
                        ds_rdata_s = ds_rdata_r;
                    end
                    if (owner_r == OWN_DATA) begin
                        ds_ack_s = 1'b1;
                    end else begin
                        if_ack_s = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge m_clk) begin
        if (!m_rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_FETCH;
            lat_cnt_r    <= 4'd0;
            starve_cnt_r <= 4'd0;
            if_ack_r     <= 1'b0;
            ds_ack_r     <= 1'b0;
            if_rdata_r   <= {DWIDTH{1'b0}};
            ds_rdata_r   <= {DWIDTH{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {AWIDTH{1'b0}};
            mem_wdata_r  <= {DWIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            lat_cnt_r    <= lat_cnt_s;
            starve_cnt_r <= starve_cnt_s;
            if_ack_r     <= if_ack_s;
            ds_ack_r     <= ds_ack_s;
            if_rdata_r   <= if_rdata_s;
            ds_rdata_r   <= ds_rdata_s;
            mem_en_r     <= mem_en_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
        end
    end

    assign bus.m_o_if_ack    = if_ack_r;
    assign bus.m_o_if_rdata  = if_rdata_r;
    assign bus.m_o_ds_ack    = ds_ack_r;
    assign bus.m_o_ds_rdata  = ds_rdata_r;
    assign bus.m_o_mem_en    = mem_en_r;
    assign bus.m_o_mem_we    = mem_we_r;
    assign bus.m_o_mem_addr  = mem_addr_r;
    assign bus.m_o_mem_wdata = mem_wdata_r;
    assign bus.m_o_busy      = (state_r != ST_IDLE);
    // Stall drops in the ack cycle so the PC can advance with the returned word.
    assign bus.m_o_if_stall  = bus.m_i_if_req & ~if_ack_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory with fixed latency,
// scoreboard of expected acks, and per-scenario timing checks.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] last_ds_exp = 32'h0000_0000;

    mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();

    mem_port_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .MEM_LATENCY(2), .STARVE_LIMIT(2)
    ) dut (
        .m_clk(clk),
        .m_rst(rst),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: written contents plus an address-derived pattern elsewhere.
    logic [31:0] mem_store [logic [31:0]];
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_a = 32'h0, p2_a = 32'h0;
    // Read data is valid only in cycle ISSUE+2; junk elsewhere exposes early/late capture.
    always @(posedge clk) begin
        #1;
        if (p2_v) bus.m_i_mem_rdata = mem_read(p2_a);
        else      bus.m_i_mem_rdata = 32'hBAD0_0BAD;
        p2_v = p1_v;
        p2_a = p1_a;
        p1_v = bus.m_o_mem_en;
        p1_a = bus.m_o_mem_addr;
        if (bus.m_o_mem_en && bus.m_o_mem_we) mem_store[bus.m_o_mem_addr] = bus.m_o_mem_wdata;
    end

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    logic [31:0] mon_got;

    // Scoreboard: every ack pops one expectation (side, cycle, data).
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (bus.m_o_if_ack && bus.m_o_ds_ack) begin
                bad++;
                $display("FAIL dual_ack: cyc=%0d if_ack=%b ds_ack=%b, required not both", cyc, bus.m_o_if_ack, bus.m_o_ds_ack);
            end
            if (bus.m_o_if_ack || bus.m_o_ds_ack) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: cyc=%0d if_ack=%b ds_ack=%b, required none", cyc, bus.m_o_if_ack, bus.m_o_ds_ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    total++;
                    if (bus.m_o_ds_ack !== mon_e.is_data) begin
                        bad++;
                        $display("FAIL ack_side: cyc=%0d ds_ack=%b, required %b", cyc, bus.m_o_ds_ack, mon_e.is_data);
                    end
                    total++;
                    if (cyc !== mon_e.cyc) begin
                        bad++;
                        $display("FAIL ack_cycle: got %0d, required %0d", cyc, mon_e.cyc);
                    end
                    mon_got = mon_e.is_data ? bus.m_o_ds_rdata : bus.m_o_if_rdata;
                    total++;
                    if (mon_got !== mon_e.rdata) begin
                        bad++;
                        $display("FAIL ack_rdata: cyc=%0d got %h, required %h", cyc, mon_got, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_data, input logic [31:0] rdata, input int ack_cyc);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        e.cyc     = ack_cyc;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.m_i_if_req = 1'b0; bus.m_i_if_addr = 32'h0;
        bus.m_i_ds_req = 1'b0; bus.m_i_ds_we = 1'b0;
        bus.m_i_ds_addr = 32'h0; bus.m_i_ds_wdata = 32'h0;
        repeat (3) tick();
        mon_en = 1'b1;
        rst = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        total++;
        if (bus.m_o_if_ack !== 1'b0 || bus.m_o_ds_ack !== 1'b0) begin
            bad++; $display("FAIL reset_acks: if=%b ds=%b, required 0 0", bus.m_o_if_ack, bus.m_o_ds_ack);
        end
        total++;
        if (bus.m_o_if_rdata !== 32'h0 || bus.m_o_ds_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: if=%h ds=%h, required 0", bus.m_o_if_rdata, bus.m_o_ds_rdata);
        end
        total++;
        if (bus.m_o_mem_en !== 1'b0 || bus.m_o_mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_mem_en_we: en=%b we=%b, required 0 0", bus.m_o_mem_en, bus.m_o_mem_we);
        end
        total++;
        if (bus.m_o_mem_addr !== 32'h0 || bus.m_o_mem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0", bus.m_o_mem_addr, bus.m_o_mem_wdata);
        end
        total++;
        if (bus.m_o_busy !== 1'b0 || bus.m_o_if_stall !== 1'b0) begin
            bad++; $display("FAIL reset_busy_stall: busy=%b stall=%b, required 0 0", bus.m_o_busy, bus.m_o_if_stall);
        end
        tick();
    endtask

    task automatic test_fetch_read();
        int t0;
        mem_store[32'h40] = 32'h2010_0005;
        t0 = cyc;
        bus.m_i_if_req = 1'b1; bus.m_i_if_addr = 32'h40;
        push_exp(1'b0, 32'h2010_0005, t0 + 4);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.m_o_if_stall !== (k < 4)) begin
                bad++; $display("FAIL fetch_stall: k=%0d got %b, required %b", k, bus.m_o_if_stall, (k < 4));
            end
            total++;
            if (bus.m_o_mem_en !== (k == 1)) begin
                bad++; $display("FAIL fetch_mem_en: k=%0d got %b, required %b", k, bus.m_o_mem_en, (k == 1));
            end
            total++;
            if (bus.m_o_busy !== (k != 0)) begin
                bad++; $display("FAIL fetch_busy: k=%0d got %b, required %b", k, bus.m_o_busy, (k != 0));
            end
            if (k == 1) begin
                total++;
                if (bus.m_o_mem_addr !== 32'h40 || bus.m_o_mem_we !== 1'b0) begin
                    bad++; $display("FAIL fetch_cmd: addr=%h we=%b, required 00000040 0", bus.m_o_mem_addr, bus.m_o_mem_we);
                end
            end
            tick();
        end
        bus.m_i_if_req = 1'b0;
    endtask

    task automatic test_priority();
        int t0;
        t0 = cyc;
        bus.m_i_if_req = 1'b1; bus.m_i_if_addr = 32'h44;
        bus.m_i_ds_req = 1'b1; bus.m_i_ds_we = 1'b0; bus.m_i_ds_addr = 32'h100;
        push_exp(1'b1, mem_read(32'h100), t0 + 4);
        push_exp(1'b0, mem_read(32'h44), t0 + 9);
        last_ds_exp = mem_read(32'h100);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            total++;
            if (bus.m_o_mem_en !== (k == 1 || k == 6)) begin
                bad++; $display("FAIL prio_mem_en: k=%0d got %b, required %b", k, bus.m_o_mem_en, (k == 1 || k == 6));
            end
            if (k == 1 || k == 6) begin
                total++;
                if (bus.m_o_mem_addr !== ((k == 1) ? 32'h100 : 32'h44)) begin
                    bad++; $display("FAIL prio_addr: k=%0d got %h, required %h", k, bus.m_o_mem_addr, (k == 1) ? 32'h100 : 32'h44);
                end
            end
            total++;
            if (bus.m_o_if_stall !== (k != 9)) begin
                bad++; $display("FAIL prio_stall: k=%0d got %b, required %b", k, bus.m_o_if_stall, (k != 9));
            end
            tick();
            if (k == 4) bus.m_i_ds_req = 1'b0;
        end
        bus.m_i_if_req = 1'b0;
    endtask

    task automatic test_starvation();
        int t0, i, j;
        bit is_f;
        logic [31:0] exp_addr;
        t0 = cyc;
        bus.m_i_if_req = 1'b1; bus.m_i_if_addr = 32'h48;
        bus.m_i_ds_req = 1'b1; bus.m_i_ds_we = 1'b0; bus.m_i_ds_addr = 32'h300;
        // With limit 2: data, data, fetch, repeating -- the repeat shows the counter cleared.
        for (int n = 0; n < 6; n++) begin
            is_f = (n % 3 == 2);
            j = (n / 3) * 2 + (n % 3);
            push_exp(!is_f, is_f ? mem_read(32'h48) : mem_read(32'h300 + 32'(4 * j)), t0 + 4 + 5 * n);
        end
        last_ds_exp = mem_read(32'h30C);
        for (int k = 0; k < 30; k++) begin
            i = k / 5;
            is_f = (i % 3 == 2);
            j = (i / 3) * 2 + (i % 3);
            @(negedge clk);
            total++;
            if (bus.m_o_mem_en !== (k % 5 == 1)) begin
                bad++; $display("FAIL starve_mem_en: k=%0d got %b, required %b", k, bus.m_o_mem_en, (k % 5 == 1));
            end
            if (k % 5 == 1) begin
                exp_addr = is_f ? 32'h48 : 32'h300 + 32'(4 * j);
                total++;
                if (bus.m_o_mem_addr !== exp_addr) begin
                    bad++; $display("FAIL starve_grant: txn=%0d addr=%h, required %h", i, bus.m_o_mem_addr, exp_addr);
                end
            end
            total++;
            if (bus.m_o_if_stall !== !(is_f && (k % 5 == 4))) begin
                bad++; $display("FAIL starve_stall: k=%0d got %b, required %b", k, bus.m_o_if_stall, !(is_f && (k % 5 == 4)));
            end
            tick();
            if ((k % 5 == 4) && !is_f) bus.m_i_ds_addr = 32'h300 + 32'(4 * (j + 1));
        end
        bus.m_i_if_req = 1'b0;
        bus.m_i_ds_req = 1'b0;
    endtask

    task automatic test_store();
        int t0;
        t0 = cyc;
        bus.m_i_ds_req = 1'b1; bus.m_i_ds_we = 1'b1;
        bus.m_i_ds_addr = 32'h200; bus.m_i_ds_wdata = 32'hDEAD_BEEF;
        push_exp(1'b1, last_ds_exp, t0 + 4);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.m_o_mem_en !== (k == 1)) begin
                bad++; $display("FAIL store_mem_en: k=%0d got %b, required %b", k, bus.m_o_mem_en, (k == 1));
            end
            if (k == 1) begin
                total++;
                if (bus.m_o_mem_we !== 1'b1 || bus.m_o_mem_addr !== 32'h200 || bus.m_o_mem_wdata !== 32'hDEAD_BEEF) begin
                    bad++; $display("FAIL store_cmd: we=%b addr=%h wdata=%h, required 1 00000200 deadbeef",
                                    bus.m_o_mem_we, bus.m_o_mem_addr, bus.m_o_mem_wdata);
                end
            end
            tick();
        end
        bus.m_i_ds_req = 1'b0; bus.m_i_ds_we = 1'b0;
        tick();
        t0 = cyc;
        bus.m_i_ds_req = 1'b1;
        push_exp(1'b1, 32'hDEAD_BEEF, t0 + 4);
        last_ds_exp = 32'hDEAD_BEEF;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (bus.m_o_mem_en !== 1'b1 || bus.m_o_mem_we !== 1'b0) begin
                    bad++; $display("FAIL reload_cmd: en=%b we=%b, required 1 0", bus.m_o_mem_en, bus.m_o_mem_we);
                end
            end
            tick();
        end
        bus.m_i_ds_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0;
        bus.m_i_if_req = 1'b1; bus.m_i_if_addr = 32'h50;
        tick();
        tick();
        rst = 1'b0;
        bus.m_i_if_req = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (bus.m_o_mem_en !== 1'b0 || bus.m_o_busy !== 1'b0) begin
                bad++; $display("FAIL midrst_idle: k=%0d en=%b busy=%b, required 0 0", k, bus.m_o_mem_en, bus.m_o_busy);
            end
            if (k == 0) begin
                total++;
                if (bus.m_o_if_rdata !== 32'h0 || bus.m_o_ds_rdata !== 32'h0) begin
                    bad++; $display("FAIL midrst_rdata: if=%h ds=%h, required 0", bus.m_o_if_rdata, bus.m_o_ds_rdata);
                end
            end
            tick();
        end
        t0 = cyc;
        bus.m_i_if_req = 1'b1; bus.m_i_if_addr = 32'h54;
        push_exp(1'b0, mem_read(32'h54), t0 + 4);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (bus.m_o_mem_en !== 1'b1 || bus.m_o_mem_addr !== 32'h54) begin
                    bad++; $display("FAIL midrst_recover: en=%b addr=%h, required 1 00000054", bus.m_o_mem_en, bus.m_o_mem_addr);
                end
            end
            tick();
        end
        bus.m_i_if_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_priority();
        test_starvation();
        test_store();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL missing_acks: %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the MIPS datapath.
- Accepts one request at a time and gives priority to data accesses. Fetch is protected from starvation by a bounded counter.
- Drives a registered memory command, waits a fixed memory latency, then returns data with a one-cycle acknowledge.
- Exposes a fetch-stall signal that lets the processor freeze the PC while instruction fetch is pending.

Parameters:
- AWIDTH, 32, address width (matches `PC_WIDTH).
- DWIDTH, 32, data width (matches `DWIDTH).
- MEM_LATENCY, 2, cycles from memory command cycle to valid m_i_mem_rdata (legal range 1..15).
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced (legal range 1..15).

Ports:
- m_clk  in  1  clock, all logic on rising edge.
- m_rst  in  1  synchronous, active-low reset.
- m_i_if_req  in  1  fetch read request; held high until m_o_if_ack.
- m_i_if_addr  in  AWIDTH  fetch address.
- m_o_if_ack  out  1  one-cycle pulse; m_o_if_rdata valid.
- m_o_if_rdata  out  DWIDTH  last fetched instruction word.
- m_o_if_stall  out  1  m_i_if_req & ~m_o_if_ack (combinational).
- m_i_ds_req  in  1  data request; held high until m_o_ds_ack.
- m_i_ds_we  in  1  1 = store, 0 = load.
- m_i_ds_addr  in  AWIDTH  data address.
- m_i_ds_wdata  in  DWIDTH  store data.
- m_o_ds_ack  out  1  one-cycle pulse; load data valid / store done.
- m_o_ds_rdata  out  DWIDTH  last loaded word.
- m_o_mem_en  out  1  memory command strobe, exactly one cycle per transaction.
- m_o_mem_we  out  1  memory write enable, qualified by m_o_mem_en.
- m_o_mem_addr  out  AWIDTH  registered command address.
- m_o_mem_wdata  out  DWIDTH  registered command write data.
- m_i_mem_rdata  in  DWIDTH  memory read data.
- m_o_busy  out  1  state != IDLE.

Behaviour:

Reset (m_rst=0 at an edge):
- State goes to IDLE.
- All registered outputs go to 0: acks, mem_en/we/addr/wdata, both rdata registers.
- Latency counter and starvation counter clear to 0; owner register clears to FETCH.

State IDLE:
- With no request, stay in IDLE.
- Otherwise select an owner:
  - ds_req only: DATA.
  - if_req only: FETCH.
  - Both requesting: DATA, unless starve_cnt == STARVE_LIMIT, in which case FETCH.
- Latch owner, addr, we (forced 0 for FETCH) and wdata into registers; go to ISSUE.
- Starvation counter:
  - DATA granted while if_req = 1: increment, saturating at STARVE_LIMIT.
  - FETCH granted: clear to 0.
  - Otherwise: unchanged.

State ISSUE:
- m_o_mem_en = 1 with the latched we/addr/wdata.
- Latency counter loads MEM_LATENCY-1; go to WAIT.

State WAIT:
- m_o_mem_en = 0.
- While the counter is non-zero, decrement it.
- When the counter is 0 (the cycle ISSUE+MEM_LATENCY):
  - For a read, capture m_i_mem_rdata into the owner's rdata register.
  - For a write, leave m_o_ds_rdata unchanged.
  - Go to RESP.

State RESP:
- Pulse the owner's ack for exactly one cycle; go to IDLE.

Latency:
- Request seen in IDLE at cycle T gives ack at cycle T+MEM_LATENCY+2 (T+4 at default).
- Back-to-back throughput is one transaction per MEM_LATENCY+3 cycles.

Handshake rules:
- A requester keeps req, addr, we and wdata stable from assertion until its ack.
- req still high in the IDLE cycle after the ack is treated as a new request.
- Request inputs are sampled only in IDLE. Changes during ISSUE, WAIT or RESP are ignored.

Other rules:
- Never more than one outstanding memory command.
- The non-owner ack never pulses.
- Both acks are never high in the same cycle.
- rdata outputs hold their value between acks.
- Reset mid-transaction (any state) aborts it: no ack is issued and no further mem_en is driven. Requesters re-request after reset.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs 0, m_o_busy=0, m_o_if_stall=0.
2. Fetch-only read at T, addr 0x40, memory returns 0x2010_0005 at ISSUE+2 -> mem_en=1 at T+1 with addr 0x40, we=0; if_ack at T+4 with if_rdata=0x2010_0005; if_stall=1 for T..T+3.
3. Simultaneous if_req (0x44) and ds_req load (0x100) -> data served first (ds_ack at T+4), fetch issued at T+6 after the IDLE cycle, if_ack at T+9.
4. STARVE_LIMIT=2, if_req held, ds_req reasserted immediately after each ack -> two data grants, then fetch granted on the third arbitration; starve_cnt returns to 0.
5. Store ds_we=1, addr 0x200, wdata 0xDEAD_BEEF -> one mem_en cycle with mem_we=1, addr/wdata matching; ds_ack at T+4; ds_rdata unchanged from its prior value.
6. m_rst=0 during WAIT of a fetch -> next cycle IDLE, no if_ack ever pulses for that request, mem_en stays 0 until a new request after reset release.
